// File: rtl/data_bus_sync_pkg.sv
// Shared constants and helpers for the data_bus_sync clock-domain crossing block.
package data_bus_sync_pkg;

   localparam int XFER_CNT_W     = 8;
   localparam int NUM_STAGES_MIN = 2;
   localparam int NUM_STAGES_MAX = 4;

   function automatic logic rise_detect(input logic level_now, input logic level_prev);
      return level_now & ~level_prev;
   endfunction

endpackage

// File: rtl/data_bus_sync_sync_chain.sv
// Multi-flop level synchronizer for the enable path into the D_CLK domain.
module sync_chain #(
   parameter int NUM_STAGES = 2
) (
   input  logic D_CLK,
   input  logic D_RST,
   input  logic async_in,
   output logic sync_out
);

   logic [NUM_STAGES-1:0] stage_r;

   // Shift the asynchronous level through the chain; stage 0 samples it directly.
   always_ff @(posedge D_CLK) begin
      if (D_RST) begin
         stage_r <= {NUM_STAGES{1'b0}};
      end else begin
         stage_r <= {stage_r[NUM_STAGES-2:0], async_in};
      end
   end

   assign sync_out = stage_r[NUM_STAGES-1];

endmodule

// File: rtl/data_bus_sync.sv
// Captures a source-held data bus on the synchronized rising edge of its enable.
module data_bus_sync
   import data_bus_sync_pkg::*;
#(
   parameter int NUM_STAGES = 2,
   parameter int BUS_WIDTH  = 8
) (
   input  logic                  D_CLK,
   input  logic                  D_RST,
   input  logic [BUS_WIDTH-1:0]  UNSYNC_BUS,
   input  logic                  UNSYNC_EN,
   output logic [BUS_WIDTH-1:0]  SYNC_BUS,
   output logic                  ENABLE_PULSE,
   output logic [XFER_CNT_W-1:0] XFER_CNT
);

   localparam int STAGES_C = (NUM_STAGES < NUM_STAGES_MIN) ? NUM_STAGES_MIN :
                             (NUM_STAGES > NUM_STAGES_MAX) ? NUM_STAGES_MAX : NUM_STAGES;

   logic                  en_s_s;
   logic                  en_d_r;
   logic                  pulse_s;
   logic [BUS_WIDTH-1:0]  sync_bus_r;
   logic                  enable_pulse_r;
   logic [XFER_CNT_W-1:0] xfer_cnt_r;

   sync_chain #(
      .NUM_STAGES (STAGES_C)
   ) u_sync_chain (
      .D_CLK    (D_CLK),
      .D_RST    (D_RST),
      .async_in (UNSYNC_EN),
      .sync_out (en_s_s)
   );

   // Rising edge of the synchronized enable; the bus is stable by now.
   always_comb begin
      pulse_s = rise_detect(en_s_s, en_d_r);
   end

   // Capture register, one-cycle strobe and transfer counter; reset beats a capture.
   always_ff @(posedge D_CLK) begin
      if (D_RST) begin
         en_d_r         <= 1'b0;
         sync_bus_r     <= {BUS_WIDTH{1'b0}};
         enable_pulse_r <= 1'b0;
         xfer_cnt_r     <= {XFER_CNT_W{1'b0}};
      end else begin
         en_d_r <= en_s_s;
         if (pulse_s) begin
            sync_bus_r     <= UNSYNC_BUS;
            enable_pulse_r <= 1'b1;
            xfer_cnt_r     <= xfer_cnt_r + {{(XFER_CNT_W-1){1'b0}}, 1'b1};
         end else begin
            enable_pulse_r <= 1'b0;
         end
      end
   end

   assign SYNC_BUS     = sync_bus_r;
   assign ENABLE_PULSE = enable_pulse_r;
   assign XFER_CNT     = xfer_cnt_r;

endmodule

// File: tb/tb_data_bus_sync.sv
// Bench for data_bus_sync: 2-stage and 3-stage instances share stimulus, checked against a sample-history model.
module tb_data_bus_sync;

   localparam int MAXE = 4096;

   logic       D_CLK = 1'b0;
   logic       D_RST = 1'b0;
   logic [7:0] UNSYNC_BUS = 8'h00;
   logic       UNSYNC_EN = 1'b0;

   logic [7:0] sync_bus_2, sync_bus_3, cnt_2, cnt_3;
   logic       pulse_2, pulse_3;

   logic [7:0] o_bus[2];
   logic [7:0] o_cnt[2];
   logic       o_pulse[2];
   assign o_bus[0] = sync_bus_2;
   assign o_bus[1] = sync_bus_3;
   assign o_cnt[0] = cnt_2;
   assign o_cnt[1] = cnt_3;
   assign o_pulse[0] = pulse_2;
   assign o_pulse[1] = pulse_3;

   data_bus_sync #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut2 (
      .D_CLK(D_CLK), .D_RST(D_RST), .UNSYNC_BUS(UNSYNC_BUS), .UNSYNC_EN(UNSYNC_EN),
      .SYNC_BUS(sync_bus_2), .ENABLE_PULSE(pulse_2), .XFER_CNT(cnt_2));

   data_bus_sync #(.NUM_STAGES(3), .BUS_WIDTH(8)) dut3 (
      .D_CLK(D_CLK), .D_RST(D_RST), .UNSYNC_BUS(UNSYNC_BUS), .UNSYNC_EN(UNSYNC_EN),
      .SYNC_BUS(sync_bus_3), .ENABLE_PULSE(pulse_3), .XFER_CNT(cnt_3));

   always #5 D_CLK = ~D_CLK;

   int checks = 0;
   int errors = 0;

   // Inputs sampled at each rising edge, indexed by edge number.
   bit         en_h[MAXE];
   bit         rst_h[MAXE];
   logic [7:0] bus_h[MAXE];
   int         edge_n = 0;

   logic [7:0] m_bus[2];
   logic [7:0] m_cnt[2];
   bit         m_pulse[2];

   // Synced level after edge k: the input seen ns-1 edges earlier, unless a reset intervened.
   function automatic bit ens(int ns, int k);
      if (k - ns + 1 < 0) return 1'b0;
      for (int j = k - ns + 1; j <= k; j++) if (rst_h[j]) return 1'b0;
      return en_h[k - ns + 1];
   endfunction

   function automatic bit cap(int ns, int k);
      return !rst_h[k] && ens(ns, k - 1) && !ens(ns, k - 2);
   endfunction

   task automatic tick();
      if (edge_n >= MAXE) begin
         errors++;
         $display("FAIL edge_budget: edge %0d, limit %0d", edge_n, MAXE);
         $fatal(1, "edge budget exhausted");
      end
      en_h[edge_n]  = UNSYNC_EN;
      rst_h[edge_n] = D_RST;
      bus_h[edge_n] = UNSYNC_BUS;
      @(posedge D_CLK);
      for (int d = 0; d < 2; d++) begin
         if (rst_h[edge_n]) begin
            m_bus[d] = 8'h00; m_cnt[d] = 8'h00; m_pulse[d] = 1'b0;
         end else if (cap(d + 2, edge_n)) begin
            m_bus[d] = bus_h[edge_n]; m_cnt[d] = m_cnt[d] + 8'd1; m_pulse[d] = 1'b1;
         end else begin
            m_pulse[d] = 1'b0;
         end
      end
      edge_n++;
      #1;
   endtask

   task automatic do_reset();
      D_RST = 1'b1; UNSYNC_EN = 1'b0;
      tick(); tick();
      D_RST = 1'b0;
   endtask

   task automatic test_reset();
      UNSYNC_BUS = 8'($urandom);
      do_reset();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({o_pulse[d], o_bus[d], o_cnt[d]} !== 17'h0) begin
            errors++;
            $display("FAIL reset_state[ns=%0d]: got pulse=%b bus=%h cnt=%0d, want 0/00/0",
                     d + 2, o_pulse[d], o_bus[d], o_cnt[d]);
         end
      end
   endtask

   task automatic test_latency();
      do_reset();
      tick();
      UNSYNC_BUS = 8'hA5; UNSYNC_EN = 1'b1;
      for (int e = 0; e < 4; e++) begin
         tick();
         checks++;
         if (pulse_2 !== (e == 2)) begin
            errors++;
            $display("FAIL latency_pulse edge %0d: got %b, want %b", e, pulse_2, (e == 2));
         end
         if (e == 2) begin
            checks++;
            if (sync_bus_2 !== 8'hA5 || cnt_2 !== 8'd1) begin
               errors++;
               $display("FAIL latency_data: got bus=%h cnt=%0d, want a5/1", sync_bus_2, cnt_2);
            end
         end
      end
      UNSYNC_EN = 1'b0;
      tick(); tick();
   endtask

   task automatic test_hold();
      int np2 = 0, np3 = 0;
      do_reset();
      UNSYNC_BUS = 8'h3C; UNSYNC_EN = 1'b1;
      for (int c = 0; c < 24; c++) begin
         if (c == 20) UNSYNC_EN = 1'b0;
         tick();
         np2 += int'(pulse_2);
         np3 += int'(pulse_3);
      end
      checks++;
      if (np2 != 1 || np3 != 1 || cnt_2 !== 8'd1 || sync_bus_2 !== 8'h3C || sync_bus_3 !== 8'h3C) begin
         errors++;
         $display("FAIL hold_single: got pulses=%0d/%0d cnt=%0d bus=%h/%h, want 1/1 1 3c/3c",
                  np2, np3, cnt_2, sync_bus_2, sync_bus_3);
      end
   endtask

   task automatic test_back_to_back();
      int pe[$];
      logic [7:0] first_bus = 8'h00;
      bit en_pat[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      do_reset();
      for (int e = 0; e < 8; e++) begin
         UNSYNC_EN  = en_pat[e];
         UNSYNC_BUS = (e < 3) ? 8'h11 : 8'h22;
         tick();
         if (pulse_2) begin
            if (pe.size() == 0) first_bus = sync_bus_2;
            pe.push_back(e);
         end
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_pulse[d], o_bus[d], o_cnt[d]} !== {m_pulse[d], m_bus[d], m_cnt[d]}) begin
               errors++;
               $display("FAIL b2b_model[ns=%0d] edge %0d: got %b/%h/%0d, want %b/%h/%0d", d + 2, e,
                        o_pulse[d], o_bus[d], o_cnt[d], m_pulse[d], m_bus[d], m_cnt[d]);
            end
         end
      end
      checks++;
      if (pe.size() != 2 || (pe.size() == 2 && pe[1] - pe[0] != 2) || first_bus !== 8'h11 ||
          sync_bus_2 !== 8'h22 || cnt_2 !== 8'd2) begin
         errors++;
         $display("FAIL b2b_spacing: got pulses=%0d first=%h final=%h cnt=%0d, want 2 pulses 2 apart 11/22/2",
                  pe.size(), first_bus, sync_bus_2, cnt_2);
      end
   endtask

   task automatic test_wrap();
      int np = 0;
      logic [7:0] last_bus = 8'h00;
      do_reset();
      for (int t = 0; t < 256; t++) begin
         last_bus = 8'($urandom);
         UNSYNC_BUS = last_bus;
         for (int c = 0; c < 4; c++) begin
            UNSYNC_EN = (c < 2);
            tick();
            for (int d = 0; d < 2; d++) begin
               checks++;
               if ({o_pulse[d], o_bus[d], o_cnt[d]} !== {m_pulse[d], m_bus[d], m_cnt[d]}) begin
                  errors++;
                  $display("FAIL wrap_model[ns=%0d] xfer %0d: got %b/%h/%0d, want %b/%h/%0d", d + 2, t,
                           o_pulse[d], o_bus[d], o_cnt[d], m_pulse[d], m_bus[d], m_cnt[d]);
               end
            end
            if (pulse_2) begin
               np++;
               if (np == 256) begin
                  checks++;
                  if (cnt_2 !== 8'd0) begin
                     errors++;
                     $display("FAIL wrap_zero: got cnt=%0d with pulse, want 0", cnt_2);
                  end
               end
            end
         end
      end
      checks++;
      if (np != 256 || sync_bus_2 !== last_bus || cnt_2 !== 8'd0 || cnt_3 !== 8'd0) begin
         errors++;
         $display("FAIL wrap_final: got pulses=%0d bus=%h cnt=%0d/%0d, want 256 %h 0/0",
                  np, sync_bus_2, cnt_2, cnt_3, last_bus);
      end
   endtask

   task automatic test_reset_mid();
      int np = 0;
      do_reset();
      UNSYNC_BUS = 8'h77; UNSYNC_EN = 1'b1;
      tick();
      D_RST = 1'b1; UNSYNC_EN = 1'b0;
      tick();
      D_RST = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         np += int'(pulse_2) + int'(pulse_3);
      end
      checks++;
      if (np != 0 || cnt_2 !== 8'd0 || sync_bus_2 !== 8'h00 || cnt_3 !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid: got pulses=%0d cnt=%0d bus=%h cnt3=%0d, want 0 0 00 0",
                  np, cnt_2, sync_bus_2, cnt_3);
      end
   endtask

   task automatic test_reset_held_en();
      D_RST = 1'b1; UNSYNC_EN = 1'b1; UNSYNC_BUS = 8'h5A;
      tick(); tick();
      D_RST = 1'b0;
      for (int e = 0; e < 6; e++) begin
         tick();
         checks++;
         if (pulse_2 !== (e == 2) || pulse_3 !== (e == 3)) begin
            errors++;
            $display("FAIL reset_release edge %0d: got %b/%b, want %b/%b", e, pulse_2, pulse_3,
                     (e == 2), (e == 3));
         end
      end
      checks++;
      if (sync_bus_2 !== 8'h5A || cnt_2 !== 8'd1 || sync_bus_3 !== 8'h5A || cnt_3 !== 8'd1) begin
         errors++;
         $display("FAIL reset_release_data: got %h/%0d %h/%0d, want 5a/1 5a/1",
                  sync_bus_2, cnt_2, sync_bus_3, cnt_3);
      end
      UNSYNC_EN = 1'b0;
   endtask

   task automatic test_ns3();
      do_reset();
      tick();
      UNSYNC_BUS = 8'hF0; UNSYNC_EN = 1'b1;
      for (int e = 0; e < 5; e++) begin
         tick();
         checks++;
         if (pulse_3 !== (e == 3)) begin
            errors++;
            $display("FAIL ns3_pulse edge %0d: got %b, want %b", e, pulse_3, (e == 3));
         end
         if (e == 3) begin
            checks++;
            if (sync_bus_3 !== 8'hF0 || cnt_3 !== 8'd1) begin
               errors++;
               $display("FAIL ns3_data: got bus=%h cnt=%0d, want f0/1", sync_bus_3, cnt_3);
            end
         end
      end
      UNSYNC_EN = 1'b0;
   endtask

   task automatic test_random();
      int hold = 0;
      bit was_pulse[2] = '{1'b0, 1'b0};
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if (hold == 0) begin
            logic nxt;
            nxt = 1'($urandom_range(0, 1));
            if (nxt && !UNSYNC_EN) UNSYNC_BUS = 8'($urandom);
            UNSYNC_EN = nxt;
            hold = $urandom_range(1, 5);
         end
         hold--;
         D_RST = ($urandom_range(0, 59) == 0);
         tick();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_pulse[d], o_bus[d], o_cnt[d]} !== {m_pulse[d], m_bus[d], m_cnt[d]} ||
                (was_pulse[d] && o_pulse[d])) begin
               errors++;
               $display("FAIL random[ns=%0d] cycle %0d: got %b/%h/%0d, want %b/%h/%0d (no double pulse)",
                        d + 2, c, o_pulse[d], o_bus[d], o_cnt[d], m_pulse[d], m_bus[d], m_cnt[d]);
            end
            was_pulse[d] = o_pulse[d];
         end
      end
      D_RST = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_bus[d] = 8'h00; m_cnt[d] = 8'h00; m_pulse[d] = 1'b0;
      end
      test_reset();
      test_latency();
      test_hold();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_reset_held_en();
      test_ns3();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_bus_sync.md
DATA_BUS_SYNC -- requirements
Module: data_bus_sync

Interface
REQ-001 Parameter NUM_STAGES, default 2, sets the synchronizer depth on the enable path; legal range 2..4.
REQ-002 Parameter BUS_WIDTH, default 8, sets the width of the data bus crossing domains.
REQ-003 D_CLK  input  1  destination-domain clock; all state updates on its rising edge.
REQ-004 D_RST  input  1  synchronous, active-high reset, sampled on rising D_CLK.
REQ-005 UNSYNC_BUS  input  BUS_WIDTH  source-domain data; the source holds it stable while UNSYNC_EN is high.
REQ-006 UNSYNC_EN  input  1  source-domain level enable; a rising transition qualifies UNSYNC_BUS.
REQ-007 SYNC_BUS  output  BUS_WIDTH  captured data, registered, held between captures.
REQ-008 ENABLE_PULSE  output  1  registered one-cycle strobe, aligned with each SYNC_BUS update.
REQ-009 XFER_CNT  output  8  registered count of completed captures, wraps 255->0.

Function
REQ-010 UNSYNC_EN shall pass through a NUM_STAGES flop chain; its last stage is the synced level EN_S.
REQ-011 A delay flop shall hold EN_S from the previous cycle (EN_D).
REQ-012 Internal pulse P = EN_S AND NOT EN_D; P is combinational and never drives an output directly.
REQ-013 On the rising D_CLK where P=1: SYNC_BUS <= UNSYNC_BUS, ENABLE_PULSE <= 1, XFER_CNT <= XFER_CNT+1 mod 256.
REQ-014 On any rising D_CLK where P=0: SYNC_BUS holds, ENABLE_PULSE <= 0, XFER_CNT holds.
REQ-015 Latency: UNSYNC_EN first sampled high at edge 0 -> EN_S high after edge NUM_STAGES-1 -> SYNC_BUS/ENABLE_PULSE update at edge NUM_STAGES; ENABLE_PULSE clears at edge NUM_STAGES+1.
REQ-016 ENABLE_PULSE shall never be high for two consecutive cycles.
REQ-017 Enable held high for any duration shall produce exactly one capture; a new capture needs EN_S to return low for at least one cycle.
REQ-018 Enable pulse shorter than one D_CLK period is not guaranteed to be captured; that is a source-side contract violation and has no detection logic.
REQ-019 Back-to-back transfers with EN_S low for exactly one cycle shall yield captures two cycles apart.
REQ-020 XFER_CNT wrap from 255 shall read 0 with ENABLE_PULSE=1 in the same cycle.

Reset
REQ-021 While D_RST=1 at a rising edge: all sync-chain flops, EN_D, SYNC_BUS, ENABLE_PULSE and XFER_CNT shall be cleared to 0.
REQ-022 D_RST takes priority over P: a capture coinciding with reset is dropped.
REQ-023 After D_RST deasserts with UNSYNC_EN already high, one capture shall occur NUM_STAGES edges later, as for a fresh rising edge.
REQ-024 Reset asserted mid-chain (enable in flight) shall discard the transfer and not count it.

Structure
REQ-025 A shared package shall hold the XFER_CNT width constant (8) and the NUM_STAGES legal bounds.
REQ-026 The enable flop chain shall be one sub-module, sync_chain (params NUM_STAGES; ports D_CLK, D_RST, async in, sync out), with synchronous active-high reset.
REQ-027 UNSYNC_BUS shall not pass through any synchronizer flop; it is sampled only by the SYNC_BUS capture register under P.
REQ-028 No logic other than flops shall sit between UNSYNC_EN and the first sync_chain stage.

Verification (NUM_STAGES=2, BUS_WIDTH=8 unless stated)
REQ-029 Reset, then UNSYNC_BUS=0xA5, UNSYNC_EN high from edge 0 -> SYNC_BUS=0xA5, ENABLE_PULSE=1 after edge 2 only, XFER_CNT=1.
REQ-030 UNSYNC_EN held high 20 cycles with UNSYNC_BUS=0x3C -> exactly one ENABLE_PULSE, XFER_CNT=1, SYNC_BUS holds 0x3C.
REQ-031 Transfers 0x11, 0x22 with EN_S low exactly one cycle between -> pulses two cycles apart, final SYNC_BUS=0x22, XFER_CNT=2.
REQ-032 256 transfers -> XFER_CNT=0 on the 256th ENABLE_PULSE; SYNC_BUS equals the last value driven.
REQ-033 D_RST=1 for one edge while enable is between stages 1 and 2 -> no ENABLE_PULSE, XFER_CNT=0, SYNC_BUS=0x00.
REQ-034 NUM_STAGES=3: UNSYNC_EN high from edge 0, UNSYNC_BUS=0xF0 -> SYNC_BUS=0xF0 and ENABLE_PULSE=1 after edge 3.
